wptr_full_ctrl: RTL
===================

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 Parameter ADDRSIZE, default 3, SHALL set the address width; FIFO depth = 2^ADDRSIZE.
REQ-002 Parameter AFULL_THRESH, default 6, SHALL set the walmost_full level threshold (1..2^ADDRSIZE).
REQ-003 wclk  input  1  SHALL be the write-domain clock; all state is on its rising edge.
REQ-004 wrst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 winc  input  1  SHALL be the write request; it is honoured only when wfull=0.
REQ-006 rptr  input  ADDRSIZE+1  SHALL be the Gray-coded read pointer from the read clock domain, asynchronous to wclk.
REQ-007 wclr_ovf  input  1  SHALL clear the sticky overflow flag.
REQ-008 waddr  output  ADDRSIZE  SHALL be the binary memory write address.
REQ-009 wptr  output  ADDRSIZE+1  SHALL be the registered Gray write pointer sent to the read domain.
REQ-010 wfull  output  1  SHALL be the registered full flag.
REQ-011 walmost_full  output  1  SHALL be the registered almost-full flag.
REQ-012 wlevel  output  ADDRSIZE+1  SHALL be the registered fill level as seen from the write domain (0..2^ADDRSIZE).
REQ-013 woverflow  output  1  SHALL be the sticky write-while-full flag.

Function
REQ-014 rptr SHALL pass through a two-flop synchronizer into wq2_rptr; a change on rptr SHALL be visible in wq2_rptr after exactly 2 wclk edges.
REQ-015 The binary pointer wbin SHALL advance as wbinnext = wbin + (winc & ~wfull), modulo 2^(ADDRSIZE+1).
REQ-016 wgraynext = (wbinnext>>1) ^ wbinnext; wbin<=wbinnext and wptr<=wgraynext SHALL be updated on the same edge.
REQ-017 waddr SHALL equal wbin[ADDRSIZE-1:0].
REQ-018 wfull SHALL register (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}), so it asserts on the edge that accepts the last free write.
REQ-019 wq2_rptr SHALL be Gray-to-binary converted to wrbin; wlevel SHALL register (wbinnext - wrbin) modulo 2^(ADDRSIZE+1).
REQ-020 walmost_full SHALL register ((wbinnext - wrbin) >= AFULL_THRESH).
REQ-021 wfull deassertion after a read SHALL occur no earlier than the 3rd wclk edge after rptr changes: 2 edges synchronizer, 1 edge flag register.
REQ-022 Write attempted while full (winc=1, wfull=1) SHALL leave wbin/wptr unchanged and set woverflow on that edge.
REQ-023 woverflow SHALL clear on wclr_ovf=1; a simultaneous overflow event SHALL win, and the flag stays 1.
REQ-024 Pointer wrap from 2^(ADDRSIZE+1)-1 to 0 SHALL be seamless; full/level logic stays correct across the wrap.

Reset
REQ-025 wrst_n=0 SHALL immediately clear wbin, wptr, both synchronizer stages, wlevel, wfull, walmost_full and woverflow to 0, regardless of wclk.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight state; after release, the first honoured write SHALL produce waddr=0 then wptr=1.

Structure
REQ-027 A shared package fifo_pkg SHALL hold the ADDRSIZE default plus bin2gray and gray2bin functions, which the read-side block also uses.
REQ-028 The two-flop synchronizer SHALL be a separate sub-module sync_r2w (width ADDRSIZE+1, wclk, wrst_n).

Verification (ADDRSIZE=3, AFULL_THRESH=6)
REQ-029 Reset, rptr=0, 8 consecutive winc -> waddr 0..7; wfull=1 after the 8th edge; wptr=4'b1100; wlevel=8.
REQ-030 From full, 9th winc -> wptr stays 4'b1100, woverflow=1; wclr_ovf with no winc -> woverflow=0; wclr_ovf together with winc -> woverflow remains 1.
REQ-031 From full, rptr changes to 4'b0001 -> wfull stays 1 for 2 edges and is 0 after the 3rd; wlevel=7.
REQ-032 From empty, 6 writes -> walmost_full=1 and wlevel=6 after the 6th edge; walmost_full=0 after the 5th edge.
REQ-033 Writes with rptr tracking wptr for 20 writes -> wptr wraps 4'b1000 -> 4'b0000 after write 16; wfull never asserts; wlevel <= 1.
REQ-034 wrst_n pulsed low between wclk edges after 5 writes -> all outputs are 0 immediately; the next honoured write gives waddr=0 and wptr=4'b0001.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width and Gray/binary pointer conversions.
// Latency: combinational helpers only.
// Backpressure: n/a (no handshake in this package).
//
// Both conversions work on a 32-bit container. Callers zero-extend their pointer
// into it and size-cast the result back, so one function pair serves every width.
package fifo_pkg;

    localparam int ADDRSIZE_DEF = 3;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
    // Zero upper bits leave the low bits unchanged.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b     = '0;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchronizer that carries the Gray read pointer into the write clock domain.
// Latency: a change on rptr is visible on wq2_rptr after exactly 2 wclk edges.
// Backpressure: none; this block samples its input on every edge.
//
// Ports: wclk, wrst_n (async active-low), rptr [WIDTH-1:0] in, wq2_rptr [WIDTH-1:0] out.
module sync_r2w #(
    parameter int WIDTH = 4
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [WIDTH-1:0] rptr,
    output logic [WIDTH-1:0] wq2_rptr
);

    logic [WIDTH-1:0] r_wq1_rptr;
    logic [WIDTH-1:0] r_wq2_rptr;

    // Gray coding keeps each transition to one bit, so a multi-bit capture is safe.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wq1_rptr <= '0;
            r_wq2_rptr <= '0;
        end else begin
            r_wq1_rptr <= rptr;
            r_wq2_rptr <= r_wq1_rptr;
        end
    end

    assign wq2_rptr = r_wq2_rptr;

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and status controller for an async FIFO: it keeps the binary and Gray write pointers and the full/almost-full/level/overflow flags.
// Latency: pointers and flags update on the accepting wclk edge; a read becomes visible no earlier than the 3rd edge after rptr moves.
// Backpressure: winc is ignored while wfull=1, and each ignored write sets the sticky woverflow flag.
//
// Ports: wclk, wrst_n (async active-low), winc, rptr[ADDRSIZE:0] (Gray, read domain),
//        wclr_ovf -> waddr[ADDRSIZE-1:0], wptr[ADDRSIZE:0] (Gray), wfull,
//        walmost_full, wlevel[ADDRSIZE:0], woverflow.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = ADDRSIZE_DEF,
    parameter int AFULL_THRESH = 6
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                wclr_ovf,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int PW = ADDRSIZE + 1;
    // The threshold is at most 2^ADDRSIZE, so it always fits in a pointer-wide value.
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr;
    logic          r_wfull;
    logic          r_walmost_full;
    logic [PW-1:0] r_wlevel;
    logic          r_woverflow;

    logic [PW-1:0] w_wq2_rptr;
    logic [PW-1:0] w_wrbin;
    logic [PW-1:0] w_wbinnext;
    logic [PW-1:0] w_wgraynext;
    logic [PW-1:0] w_full_gray;
    logic [PW-1:0] w_level_next;
    logic          w_winc_ok;
    logic          w_ovf_evt;

    sync_r2w #(
        .WIDTH (PW)
    ) u_sync_r2w (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .rptr     (rptr),
        .wq2_rptr (w_wq2_rptr)
    );

    assign w_winc_ok   = winc & ~r_wfull;
    assign w_ovf_evt   = winc & r_wfull;
    assign w_wbinnext  = r_wbin + PW'(w_winc_ok);
    assign w_wgraynext = PW'(bin2gray(32'(w_wbinnext)));
    assign w_wrbin     = PW'(gray2bin(32'(w_wq2_rptr)));

    // Full means the write pointer is exactly one lap ahead of the synchronized
    // read pointer. In Gray code that is the read pointer with its top two bits
    // inverted. This needs ADDRSIZE >= 2.
    assign w_full_gray  = {~w_wq2_rptr[PW-1:PW-2], w_wq2_rptr[PW-3:0]};

    // Modulo subtraction keeps the level correct across the pointer wrap.
    assign w_level_next = w_wbinnext - w_wrbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbinnext;
            r_wptr         <= w_wgraynext;
            r_wfull        <= (w_wgraynext == w_full_gray);
            r_walmost_full <= (w_level_next >= AFULL_LVL);
            r_wlevel       <= w_level_next;
            // A new overflow takes priority over a clear on the same edge.
            if (w_ovf_evt) begin
                r_woverflow <= 1'b1;
            end else if (wclr_ovf) begin
                r_woverflow <= 1'b0;
            end
        end
    end

    assign waddr        = r_wbin[ADDRSIZE-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
    assign woverflow    = r_woverflow;

endmodule
